// File: rtl/soc_bus_if.sv
// Bus bundle between the hs32 CPU external port, the interconnect and the SoC slaves.
// The master modport is the CPU's view, the slave modport a slave's view, and ic is
// the view of the interconnect that sits between them.
interface soc_bus_if #(
    parameter int NSLAVES = 4,
    parameter int AW      = 32,
    parameter int DW      = 32
);
    logic [AW-1:0]         m_addr;
    logic                  m_rw;
    logic [DW-1:0]         m_dwrite;
    logic                  m_valid;
    logic [DW-1:0]         m_dread;
    logic                  m_ready;
    logic                  m_err;

    logic [AW-1:0]         s_addr;
    logic                  s_rw;
    logic [DW-1:0]         s_dwrite;
    logic [NSLAVES-1:0]    s_valid;
    logic [NSLAVES-1:0]    s_ready;
    logic [NSLAVES*DW-1:0] s_dread;

    modport master (
        output m_addr, m_rw, m_dwrite, m_valid,
        input  m_dread, m_ready, m_err
    );

    modport slave (
        input  s_addr, s_rw, s_dwrite, s_valid,
        output s_ready, s_dread
    );

    modport ic (
        input  m_addr, m_rw, m_dwrite, m_valid,
        output m_dread, m_ready, m_err,
        output s_addr, s_rw, s_dwrite, s_valid,
        input  s_ready, s_dread
    );
endinterface

// File: rtl/soc_bus_ic.sv
// Single-master, N-slave interconnect: decodes the top address bits into a slave
// select, registers the request onto the shared slave bus, and returns read data.
// Unmapped addresses and slaves that never answer are completed with m_err and
// ERR_DATA so the CPU can never stall forever on the bus.
//
// state  | meaning
// IDLE   | waiting for m_valid
// REQ    | s_valid held to the selected slave, watchdog running
// RESP   | m_ready pulse, normal completion
// ERR    | m_ready + m_err pulse, decode error or watchdog timeout
module soc_bus_ic #(
    parameter int            NSLAVES  = 4,
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            SEL_W    = 2,
    parameter int            TIMEOUT  = 255,
    parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF)
) (
    input  logic       clk,
    input  logic       reset_n,
    soc_bus_if.ic      bus,
    output logic [7:0] err_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // A zero TIMEOUT still needs a legal (unused) one-bit counter.
    localparam int              WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic [1:0]         state;
    logic [NSLAVES-1:0] valid_q;
    logic               ready_q;
    logic               err_q;
    logic [DW-1:0]      dread_q;
    logic [AW-1:0]      addr_q;
    logic               rw_q;
    logic [DW-1:0]      wdata_q;
    logic [7:0]         err_cnt_q;
    logic [WD_W-1:0]    wdog;

    logic [SEL_W-1:0]   sel_in;
    logic               mapped;
    logic [NSLAVES-1:0] sel_onehot;
    logic               hit;
    logic               timed_out;
    logic [DW-1:0]      rdata_sel;

    assign sel_in     = bus.m_addr[AW-1 -: SEL_W];
    assign mapped     = (int'(sel_in) < NSLAVES);
    assign sel_onehot = NSLAVES'(1) << sel_in;
    // valid_q is one-hot on the selected slave, so ready bits of other slaves drop out here.
    assign hit        = |(bus.s_ready & valid_q);
    assign timed_out  = (TIMEOUT != 0) && (wdog == WD_MAX);

    // Read-data mux keyed on the one-hot select held in valid_q.
    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            if (valid_q[k]) begin
                rdata_sel = bus.s_dread[k*DW +: DW];
            end
        end
    end

    // Transaction FSM; every bus output is a flop so nothing combinational reaches the ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            valid_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            dread_q   <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            err_cnt_q <= '0;
            wdog      <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.m_valid) begin
                        addr_q  <= bus.m_addr;
                        rw_q    <= bus.m_rw;
                        wdata_q <= bus.m_dwrite;
                        wdog    <= '0;
                        if (mapped) begin
                            valid_q <= sel_onehot;
                            state   <= S_REQ;
                        end else begin
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            dread_q <= ERR_DATA;
                            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                            state   <= S_ERR;
                        end
                    end
                end
                S_REQ: begin
                    // A slave answer in the watchdog's last cycle still completes normally.
                    if (hit) begin
                        valid_q <= '0;
                        ready_q <= 1'b1;
                        dread_q <= rdata_sel;
                        state   <= S_RESP;
                    end else if (timed_out) begin
                        valid_q <= '0;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        dread_q <= ERR_DATA;
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        state   <= S_ERR;
                    end else if (wdog != WD_MAX) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_RESP, S_ERR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m_ready  = ready_q;
    assign bus.m_err    = err_q;
    assign bus.m_dread  = dread_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_rw     = rw_q;
    assign bus.s_dwrite = wdata_q;
    assign bus.s_valid  = valid_q;
    assign err_count    = err_cnt_q;
endmodule

// File: tb/tb_soc_bus_ic.sv
// Bench for soc_bus_ic: a four-slave instance (watchdog 8) covers reads, writes,
// latency, stray ready, timeout and back-to-back requests; a three-slave instance
// covers unmapped decode and err_count saturation. Expected completions are queued
// when a request is driven and checked when m_ready appears.
module tb_soc_bus_ic;
    localparam logic [31:0] ERR_D = 32'hDEADBEEF;

    typedef struct {
        logic        err;
        logic        cd;
        logic [31:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] err_cnt4;
    logic [7:0] err_cnt3;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_rdy4 = 0;
    int         n_rdy3 = 0;
    int         saved_rdy;
    exp_t       q4[$];
    exp_t       q3[$];

    always #5 clk = ~clk;

    soc_bus_if #(.NSLAVES(4), .AW(32), .DW(32)) bus4 ();
    soc_bus_if #(.NSLAVES(3), .AW(32), .DW(32)) bus3 ();

    soc_bus_ic #(.NSLAVES(4), .AW(32), .DW(32), .SEL_W(2), .TIMEOUT(8), .ERR_DATA(ERR_D)) u_dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus4),
        .err_count (err_cnt4)
    );

    soc_bus_ic #(.NSLAVES(3), .AW(32), .DW(32), .SEL_W(2), .TIMEOUT(8), .ERR_DATA(ERR_D)) u_dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus3),
        .err_count (err_cnt3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the four-slave instance.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus4.m_ready === 1'b1) begin
            n_rdy4++;
            chk("sb4_pending", 64'(q4.size() != 0), 64'd1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                chk("sb4_m_err", 64'(bus4.m_err), 64'(e.err));
                if (e.cd) chk("sb4_m_dread", 64'(bus4.m_dread), 64'(e.data));
            end
        end
    end

    // Scoreboard for the three-slave instance.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus3.m_ready === 1'b1) begin
            n_rdy3++;
            chk("sb3_pending", 64'(q3.size() != 0), 64'd1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                chk("sb3_m_err", 64'(bus3.m_err), 64'(e.err));
                chk("sb3_m_dread", 64'(bus3.m_dread), 64'(e.data));
            end
        end
    end

    // k = cycle in which the selected slave pulses s_ready (0 = never);
    // b2b = m_valid is already driven from the previous call; hold = keep m_valid afterwards.
    task automatic txn4(input logic [31:0] addr, input logic rw, input logic [31:0] wd,
                        input int k, input logic [31:0] rd, input logic [3:0] stray,
                        input logic exp_err, input int exp_lat, input logic b2b, input logic hold);
        logic [1:0] sel;
        logic [3:0] oh;
        exp_t       e;
        logic       done;
        sel = addr[31:30];
        oh  = 4'b0001 << sel;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        bus4.m_addr   = addr;
        bus4.m_rw     = rw;
        bus4.m_dwrite = wd;
        bus4.m_valid  = 1'b1;
        for (int j = 0; j < 4; j++)
            bus4.s_dread[j*32 +: 32] = (j == int'(sel)) ? rd : (32'hBAD0_0000 | 32'(j));
        e.err  = exp_err;
        e.cd   = exp_err | ~rw;
        e.data = exp_err ? ERR_D : rd;
        q4.push_back(e);
        @(posedge clk);
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            #1;
            bus4.s_ready = (c == k) ? oh : ((c < k) ? stray : 4'b0000);
            @(negedge clk);
            if (bus4.m_ready) begin
                done = 1'b1;
                chk("latency", 64'(c), 64'(exp_lat));
                chk("s_valid_at_ready", 64'(bus4.s_valid), 64'd0);
            end else begin
                chk("s_valid_held", 64'(bus4.s_valid), 64'(oh));
                if (c == 1) begin
                    chk("s_addr", 64'(bus4.s_addr), 64'(addr));
                    chk("s_rw", 64'(bus4.s_rw), 64'(rw));
                    chk("s_dwrite", 64'(bus4.s_dwrite), 64'(wd));
                end
            end
            @(posedge clk);
        end
        chk("ready_seen", 64'(done), 64'd1);
        #1;
        bus4.s_ready = 4'b0000;
        if (!hold) bus4.m_valid = 1'b0;
    endtask

    task automatic txn3_unmapped(input logic [31:0] addr);
        exp_t e;
        logic done;
        @(posedge clk);
        #1;
        bus3.m_addr  = addr;
        bus3.m_rw    = 1'b0;
        bus3.m_valid = 1'b1;
        e.err  = 1'b1;
        e.cd   = 1'b1;
        e.data = ERR_D;
        q3.push_back(e);
        @(posedge clk);
        done = 1'b0;
        for (int c = 1; c <= 4 && !done; c++) begin
            @(negedge clk);
            if (bus3.m_ready) begin
                done = 1'b1;
                chk("unmapped_latency", 64'(c), 64'd1);
                chk("unmapped_s_valid", 64'(bus3.s_valid), 64'd0);
            end
            @(posedge clk);
        end
        chk("unmapped_ready_seen", 64'(done), 64'd1);
        #1;
        bus3.m_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        bus4.m_addr = '0; bus4.m_rw = 1'b0; bus4.m_dwrite = '0; bus4.m_valid = 1'b0;
        bus4.s_ready = '0; bus4.s_dread = '0;
        bus3.m_addr = '0; bus3.m_rw = 1'b0; bus3.m_dwrite = '0; bus3.m_valid = 1'b0;
        bus3.s_ready = '0; bus3.s_dread = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_ready", 64'(bus4.m_ready), 64'd0);
        chk("rst_m_err", 64'(bus4.m_err), 64'd0);
        chk("rst_m_dread", 64'(bus4.m_dread), 64'd0);
        chk("rst_s_valid", 64'(bus4.s_valid), 64'd0);
        chk("rst_s_addr", 64'(bus4.s_addr), 64'd0);
        chk("rst_err_count", 64'(err_cnt4), 64'd0);
        reset_n = 1'b1;

        txn4(32'h0000_0010, 1'b0, 32'h0,         3, 32'hCAFEF00D, 4'b0000, 1'b0,  4, 1'b0, 1'b0);
        txn4(32'h8000_0004, 1'b1, 32'h12345678, 2, 32'h0BADF00D, 4'b0000, 1'b0,  3, 1'b0, 1'b0);
        txn4(32'h4000_0008, 1'b0, 32'h0,         1, 32'h1111_2222, 4'b0000, 1'b0,  2, 1'b0, 1'b0);
        txn4(32'h4000_0020, 1'b0, 32'h0,         4, 32'h3333_4444, 4'b1000, 1'b0,  5, 1'b0, 1'b0);
        chk("err_count_no_err", 64'(err_cnt4), 64'd0);
        txn4(32'hC000_0100, 1'b0, 32'h0,         0, 32'h0,         4'b0000, 1'b1, 10, 1'b0, 1'b0);
        chk("err_count_timeout", 64'(err_cnt4), 64'd1);
        txn4(32'hC000_0104, 1'b0, 32'h0,         9, 32'h5555_6666, 4'b0000, 1'b0, 10, 1'b0, 1'b0);
        chk("err_count_last_cycle", 64'(err_cnt4), 64'd1);
        txn4(32'h8000_0040, 1'b0, 32'h0,         2, 32'h7777_8888, 4'b0000, 1'b0,  3, 1'b0, 1'b1);
        txn4(32'h8000_0040, 1'b0, 32'h0,         1, 32'h9999_AAAA, 4'b0000, 1'b0,  2, 1'b1, 1'b0);
        chk("sb4_drained", 64'(q4.size()), 64'd0);

        // Reset in the middle of a request to slave 1.
        @(posedge clk);
        #1;
        bus4.m_addr  = 32'h4000_0000;
        bus4.m_rw    = 1'b0;
        bus4.m_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_s_valid_pre", 64'(bus4.s_valid), 64'b0010);
        saved_rdy    = n_rdy4;
        reset_n      = 1'b0;
        bus4.m_valid = 1'b0;
        #1;
        chk("abort_s_valid", 64'(bus4.s_valid), 64'd0);
        chk("abort_m_ready", 64'(bus4.m_ready), 64'd0);
        chk("abort_m_dread", 64'(bus4.m_dread), 64'd0);
        chk("abort_s_addr", 64'(bus4.s_addr), 64'd0);
        chk("abort_err_count", 64'(err_cnt4), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_ready", 64'(n_rdy4), 64'(saved_rdy));
        chk("abort_s_valid_post", 64'(bus4.s_valid), 64'd0);

        // Unmapped decode and err_count saturation on the three-slave instance.
        txn3_unmapped(32'hC000_0000);
        chk("err_count_unmapped", 64'(err_cnt3), 64'd1);
        for (int i = 2; i <= 300; i++) begin
            txn3_unmapped(32'hC000_0000 | 32'(i << 2));
            if (i == 254) chk("err_count_254", 64'(err_cnt3), 64'd254);
            if (i == 255) chk("err_count_255", 64'(err_cnt3), 64'd255);
        end
        chk("err_count_saturated", 64'(err_cnt3), 64'd255);
        chk("sb3_all_ready", 64'(n_rdy3), 64'd300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
